// File: rtl/int_to_fpu.sv
// Signed integer to FPU operand encoder {s, e[6:0], m[14:0]}.
// Normalizes iteratively, one left shift per clock, with a start/idle/done handshake.
module int_to_fpu #(
    parameter int unsigned INT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [INT_W-1:0] int_in,
    output logic             res_s,
    output logic [6:0]       res_e,
    output logic [14:0]      res_m,
    output logic             idle,
    output logic             done
);

    localparam int unsigned MSB   = INT_W - 1;
    localparam int unsigned MAN_W = 15;
    localparam int unsigned EXP_W = 7;

    typedef enum logic {
        IDLE = 1'b0,
        NORM = 1'b1
    } state_t;

    state_t             state;
    logic               sgn;
    logic [INT_W-1:0]   mag;
    logic [EXP_W-1:0]   cnt;

    // Single-process FSM; every output is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sgn   <= 1'b0;
            mag   <= '0;
            cnt   <= '0;
            res_s <= 1'b0;
            res_e <= '0;
            res_m <= '0;
            idle  <= 1'b1;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    idle <= 1'b1;
                    if (start) begin
                        // The most negative input negates to itself, which reads as 2^(INT_W-1) unsigned.
                        sgn   <= int_in[MSB];
                        mag   <= int_in[MSB] ? -int_in : int_in;
                        cnt   <= EXP_W'(INT_W - 1);
                        idle  <= 1'b0;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (mag == '0) begin
                        res_s <= 1'b0;
                        res_e <= 7'h40;
                        res_m <= '0;
                        done  <= 1'b1;
                        idle  <= 1'b1;
                        state <= IDLE;
                    end else if (mag[MSB]) begin
                        // Truncate: bits below the top 15 are dropped.
                        res_s <= sgn;
                        res_e <= cnt;
                        res_m <= mag[MSB -: MAN_W];
                        done  <= 1'b1;
                        idle  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        mag <= mag << 1;
                        cnt <= cnt - EXP_W'(1);
                    end
                end
                default: begin
                    idle  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_fpu.sv
// Directed self-checking bench for int_to_fpu at INT_W=16.
module tb_int_to_fpu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] int_in;
    logic        res_s;
    logic [6:0]  res_e;
    logic [14:0] res_m;
    logic        idle;
    logic        done;

    int n_cmp;
    int n_fail;

    int_to_fpu #(.INT_W(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .int_in (int_in),
        .res_s  (res_s),
        .res_e  (res_e),
        .res_m  (res_m),
        .idle   (idle),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one conversion and report what came back; latency 0 means no done seen.
    task automatic convert(input logic [15:0] val, output logic s, output logic [6:0] e,
                           output logic [14:0] m, output int lat, output logic idl);
        @(negedge clk);
        start  = 1'b1;
        int_in = val;
        @(posedge clk);
        #1;
        start  = 1'b0;
        int_in = ~val;
        lat = 0;
        s = 1'b0; e = '0; m = '0; idl = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k; s = res_s; e = res_e; m = res_m; idl = idle;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if (idle !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: idle=%b done=%b want idle=1 done=0", idle, done);
        end
        n_cmp++;
        if (res_s !== 1'b0 || res_e !== 7'h00 || res_m !== 15'h0000) begin
            n_fail++; $display("FAIL reset_res: s=%b e=%h m=%h want 0/00/0000", res_s, res_e, res_m);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (idle !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: idle=%b done=%b want 1/0", idle, done);
        end
    endtask

    task automatic test_one;
        logic s; logic [6:0] e; logic [14:0] m; int lat; logic idl;
        convert(16'h0001, s, e, m, lat, idl);
        n_cmp++;
        if (lat !== 16) begin n_fail++; $display("FAIL one_latency: got %0d want 16", lat); end
        n_cmp++;
        if (s !== 1'b0 || e !== 7'h00 || m !== 15'h4000) begin
            n_fail++; $display("FAIL one_result: s=%b e=%h m=%h want 0/00/4000", s, e, m);
        end
        n_cmp++;
        if (idl !== 1'b1) begin n_fail++; $display("FAIL one_idle_in_done: got %b want 1", idl); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0 || res_m !== 15'h4000) begin
            n_fail++; $display("FAIL one_done_pulse: done=%b m=%h want 0/4000", done, res_m);
        end
    endtask

    task automatic test_values;
        logic [15:0] vin [5];
        logic        xs  [5];
        logic [6:0]  xe  [5];
        logic [14:0] xm  [5];
        int          xl  [5];
        logic s; logic [6:0] e; logic [14:0] m; int lat; logic idl;
        vin = '{16'h3039, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
        xs  = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
        xe  = '{7'h0D,    7'h00,    7'h0E,    7'h0F,    7'h40};
        xm  = '{15'h6072, 15'h4000, 15'h7FFF, 15'h4000, 15'h0000};
        xl  = '{3,        16,       2,        1,        1};
        for (int i = 0; i < 5; i++) begin
            convert(vin[i], s, e, m, lat, idl);
            n_cmp++;
            if (lat !== xl[i]) begin
                n_fail++; $display("FAIL val_latency[%h]: got %0d want %0d", vin[i], lat, xl[i]);
            end
            n_cmp++;
            if (s !== xs[i] || e !== xe[i] || m !== xm[i]) begin
                n_fail++;
                $display("FAIL val_result[%h]: s=%b e=%h m=%h want %b/%h/%h",
                         vin[i], s, e, m, xs[i], xe[i], xm[i]);
            end
            n_cmp++;
            if (idl !== 1'b1) begin
                n_fail++; $display("FAIL val_idle_in_done[%h]: got %b want 1", vin[i], idl);
            end
        end
    endtask

    task automatic test_back_to_back;
        int ndone;
        int bad_idle;
        ndone = 0;
        bad_idle = 0;
        @(negedge clk);
        start  = 1'b1;
        int_in = 16'h8000;
        @(posedge clk);
        // Accepts on even edges, done on odd; start drops after the accept at edge 12.
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (idle !== 1'b1) bad_idle++;
            end
            if (k == 12) start = 1'b0;
        end
        n_cmp++;
        if (ndone !== 7) begin n_fail++; $display("FAIL b2b_count: got %0d want 7", ndone); end
        n_cmp++;
        if (bad_idle !== 0) begin n_fail++; $display("FAIL b2b_idle: %0d done cycles with idle=0, want 0", bad_idle); end
        n_cmp++;
        if (res_s !== 1'b1 || res_e !== 7'h0F || res_m !== 15'h4000) begin
            n_fail++; $display("FAIL b2b_result: s=%b e=%h m=%h want 1/0F/4000", res_s, res_e, res_m);
        end
    endtask

    task automatic test_ignore;
        int ndone;
        int lat;
        ndone = 0;
        lat = 0;
        @(negedge clk);
        start  = 1'b1;
        int_in = 16'h0001;
        @(posedge clk);
        #1;
        start  = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk);
            #1;
            if (done) begin ndone++; lat = k; end
            if (k == 4) begin start = 1'b1; int_in = 16'h7FFF; end
            if (k == 5) start = 1'b0;
        end
        n_cmp++;
        if (ndone !== 1) begin n_fail++; $display("FAIL ignore_count: got %0d want 1", ndone); end
        n_cmp++;
        if (lat !== 16) begin n_fail++; $display("FAIL ignore_latency: got %0d want 16", lat); end
        n_cmp++;
        if (res_s !== 1'b0 || res_e !== 7'h00 || res_m !== 15'h4000) begin
            n_fail++; $display("FAIL ignore_result: s=%b e=%h m=%h want 0/00/4000", res_s, res_e, res_m);
        end
    endtask

    task automatic test_reset_mid;
        int ndone;
        logic s; logic [6:0] e; logic [14:0] m; int lat; logic idl;
        ndone = 0;
        @(negedge clk);
        start  = 1'b1;
        int_in = 16'h0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (idle !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL midreset_ctrl: idle=%b done=%b want 1/0", idle, done);
        end
        n_cmp++;
        if (res_s !== 1'b0 || res_e !== 7'h00 || res_m !== 15'h0000) begin
            n_fail++; $display("FAIL midreset_res: s=%b e=%h m=%h want 0/00/0000", res_s, res_e, res_m);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d want 0", ndone); end
        convert(16'h0002, s, e, m, lat, idl);
        n_cmp++;
        if (lat !== 15) begin n_fail++; $display("FAIL after_reset_latency: got %0d want 15", lat); end
        n_cmp++;
        if (s !== 1'b0 || e !== 7'h01 || m !== 15'h4000) begin
            n_fail++; $display("FAIL after_reset_result: s=%b e=%h m=%h want 0/01/4000", s, e, m);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        start  = 1'b0;
        int_in = '0;
        test_reset;
        test_one;
        test_values;
        test_back_to_back;
        test_ignore;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
